alu_unit: RTL and testbench
===========================

# alu_unit

Execute stage of the RISC-V core, directly downstream of `control_unit`. Consumes the 4-bit `alu_control` code and two 32-bit operands, and produces a registered result with a start/done handshake. Most operations finish in one cycle. `div` and `rem` use an iterative 32-step signed divider. While an operation is in flight, `busy` stalls the core.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request pulse; sampled only when `busy`=0.
- `alu_control`  in  4  op code: 0000 add, 0001 and, 0010 sub, 0011 slt, 0100 div, 0101 rem, 0110 sll, 0111 srl, 1000 sra; 1001–1111 are undefined.
- `a`  in  32  operand rs1; captured at start.
- `b`  in  32  operand rs2; captured at start.
- `result`  out  32  registered result; holds until the next completion.
- `zero`  out  1  combinational `result==0`.
- `busy`  out  1  high whenever state≠IDLE.
- `done`  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, DIV, DONE.
- IDLE with `start`=1: capture `alu_control`, `a`, `b`.
  - Non-div ops: compute, load `result`, go to DONE.
  - div/rem with b=0: div → 0xFFFFFFFF; rem → a; go to DONE.
  - div/rem with a=0x80000000 and b=0xFFFFFFFF: div → 0x80000000; rem → 0; go to DONE.
  - Any other div/rem: load magnitudes |a| and |b|, record quotient sign (a[31]^b[31]) and remainder sign (a[31]), clear the 6-bit step counter, go to DIV.
- DIV runs a restoring divider, one quotient bit per cycle, MSB first:
  - Each step: rem = {rem[30:0], dvd[31]}, shift dvd left; if rem ≥ |b|, subtract |b| and set the quotient bit to 1.
  - After step 32: apply the sign to the quotient (div) or remainder (rem), load `result`, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Arithmetic rules:
  - add/sub wrap modulo 2^32.
  - slt is signed; the result is 0 or 1.
  - Shift amount is b[4:0]; sra replicates a[31].
  - Division truncates toward zero; the remainder takes the sign of the dividend.
  - Undefined codes give `result`=0 with a normal one-cycle completion.
- `start` while `busy`=1 is ignored. It is not queued.
- Operands and `alu_control` may change after the start cycle without effect.

## Timing
- Reset values (the cycle after `reset` is sampled high): state IDLE, `result`=0, `zero`=1, `busy`=0, `done`=0, counter 0.
- Let cycle 0 be the cycle in which `start` is sampled.
- Latency:
  - Non-div ops and div/rem special cases: `result` is valid and `done`=1 in cycle 1.
  - Regular div/rem: `done`=1 in cycle 33; `busy`=1 in cycles 1–33.
- The earliest next accepted `start` is in the cycle after `done` (cycle 2 or 34). Sustained throughput is one op per 2 cycles for single-cycle ops.
- `reset` mid-DIV aborts the operation: no `done` pulse, and all outputs return to reset values the next cycle.
- `reset` and `start` high in the same cycle: reset wins and the start is dropped.
- `result` changes only on a completion edge or on reset.

## Test plan
- Reset, then sub a=100, b=7 → cycle 1: `result`=93, `done`=1, `zero`=0; cycle 2: `busy`=0.
- div a=0xFFFFFFEC (−20), b=3 → `busy` high cycles 1–33; cycle 33: `result`=0xFFFFFFFA, `done`=1. rem with the same operands → 0xFFFFFFFE.
- div 5/0 → cycle 1: 0xFFFFFFFF. rem 5/0 → 5. div 0x80000000/0xFFFFFFFF → 0x80000000. rem with the same operands → 0 and `zero`=1.
- sra a=0x80000000, b=0x24 → 0xF8000000 (shift 4). srl with the same operands → 0x08000000. slt a=0xFFFFFFFF, b=1 → 1.
- Start div 100/7, pulse `start` with add at cycle 5 → add is ignored; cycle 33: `result`=14, then exactly one `done`.
- Start div 100/7, assert `reset` at cycle 10 → cycle 11: `busy`=0, `result`=0; no `done` through cycle 40.

Source files
------------

// File: rtl/alu_unit.sv
// Execute-stage ALU: single-cycle ops plus an iterative 32-step signed divider,
// with a registered result and a start/busy/done handshake.
module alu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   localparam logic [3:0] OP_ADD = 4'b0000, OP_AND = 4'b0001, OP_SUB = 4'b0010,
                          OP_SLT = 4'b0011, OP_DIV = 4'b0100, OP_REM = 4'b0101,
                          OP_SLL = 4'b0110, OP_SRL = 4'b0111, OP_SRA = 4'b1000;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic [5:0]       cnt;
   logic [WIDTH-1:0] dvd, dvs, rem;
   logic             is_rem, q_neg, r_neg;

   logic [WIDTH-1:0] alu_out, rem_sh, rem_nx, quo_nx;
   logic             rem_ge, is_div_op;

   assign zero      = (result == '0);
   assign busy      = (state != IDLE);
   assign is_div_op = (alu_control == OP_DIV) || (alu_control == OP_REM);

   always_comb begin
      alu_out = '0;
      case (alu_control)
         OP_ADD: alu_out = a + b;
         OP_AND: alu_out = a & b;
         OP_SUB: alu_out = a - b;
         OP_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL: alu_out = a << b[4:0];
         OP_SRL: alu_out = a >> b[4:0];
         OP_SRA: alu_out = $signed(a) >>> b[4:0];
         default: alu_out = '0;
      endcase
   end

   // Restoring step: dividend shifts out MSB-first, quotient bits shift into its LSB.
   always_comb begin
      rem_sh = {rem[WIDTH-2:0], dvd[WIDTH-1]};
      rem_ge = (rem_sh >= dvs);
      rem_nx = rem_ge ? (rem_sh - dvs) : rem_sh;
      quo_nx = {dvd[WIDTH-2:0], rem_ge};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         result <= '0;
         done   <= 1'b0;
         cnt    <= '0;
         dvd    <= '0;
         dvs    <= '0;
         rem    <= '0;
         is_rem <= 1'b0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (!is_div_op) begin
                  result <= alu_out;
                  done   <= 1'b1;
                  state  <= DONE;
               end else if (b == '0) begin
                  result <= (alu_control == OP_DIV) ? '1 : a;
                  done   <= 1'b1;
                  state  <= DONE;
               end else if (a == MIN_NEG && b == '1) begin
                  result <= (alu_control == OP_DIV) ? MIN_NEG : '0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  dvd    <= a[WIDTH-1] ? -a : a;
                  dvs    <= b[WIDTH-1] ? -b : b;
                  rem    <= '0;
                  cnt    <= '0;
                  is_rem <= (alu_control == OP_REM);
                  q_neg  <= a[WIDTH-1] ^ b[WIDTH-1];
                  r_neg  <= a[WIDTH-1];
                  state  <= DIV;
               end
            end
            DIV: begin
               rem <= rem_nx;
               dvd <= quo_nx;
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) begin
                  if (is_rem) result <= r_neg ? -rem_nx : rem_nx;
                  else        result <= q_neg ? -quo_nx : quo_nx;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed cases plus random ops checked against an arithmetic model.
module tb_alu_unit;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [3:0]  alu_control;
   logic [31:0] a, b, result;
   logic        zero, busy, done;

   int total = 0;
   int bad   = 0;

   alu_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
      .a(a), .b(b), .result(result), .zero(zero), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit is_ovf(input logic [31:0] x, input logic [31:0] y);
      return (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
      int sx, sy, sh;
      sx = x; sy = y; sh = int'(y & 32'h1F);
      case (op)
         4'd0: return x + y;
         4'd1: return x & y;
         4'd2: return x - y;
         4'd3: return (sx < sy) ? 32'd1 : 32'd0;
         4'd4: if (y == 0) return 32'hFFFF_FFFF;
               else if (is_ovf(x, y)) return 32'h8000_0000;
               else return sx / sy;
         4'd5: if (y == 0) return x;
               else if (is_ovf(x, y)) return 32'd0;
               else return sx % sy;
         4'd6: return x << sh;
         4'd7: return x >> sh;
         4'd8: return sx >>> sh;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [31:0] x,
                                  input logic [31:0] y);
      if ((op == 4'd4 || op == 4'd5) && y != 0 && !is_ovf(x, y)) return 33;
      return 1;
   endfunction

   task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y);
      logic [31:0] exp;
      int lat, explat;
      bit bsy_ok;
      exp = ref_res(op, x, y);
      explat = ref_lat(op, x, y);
      @(negedge clk);
      start = 1'b1; alu_control = op; a = x; b = y;
      @(negedge clk);
      // Scramble inputs: the captured values must be the only ones that matter.
      start = 1'b0; alu_control = 4'($urandom); a = $urandom; b = $urandom;
      lat = 1; bsy_ok = 1'b1;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1) bsy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (busy !== 1'b1) bsy_ok = 1'b0;
      chk({tag, " latency"}, 32'(lat), 32'(explat));
      chk({tag, " result"}, result, exp);
      chk({tag, " zero"}, {31'd0, zero}, {31'd0, exp == 0});
      chk({tag, " busy_in_flight"}, {31'd0, bsy_ok}, 32'd1);
      @(negedge clk);
      chk({tag, " done_drops"}, {31'd0, done}, 32'd0);
      chk({tag, " idle_after"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int dones;
      logic [3:0]  op;
      logic [31:0] x, y;
      reset = 1'b1; start = 1'b0; alu_control = '0; a = '0; b = '0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      chk("reset result", result, 32'd0);
      chk("reset zero", {31'd0, zero}, 32'd1);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);

      do_op("sub", 4'd2, 32'd100, 32'd7);
      do_op("div_neg", 4'd4, 32'hFFFF_FFEC, 32'd3);
      do_op("rem_neg", 4'd5, 32'hFFFF_FFEC, 32'd3);
      do_op("div_by0", 4'd4, 32'd5, 32'd0);
      do_op("rem_by0", 4'd5, 32'd5, 32'd0);
      do_op("div_ovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op("rem_ovf", 4'd5, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op("sra", 4'd8, 32'h8000_0000, 32'h24);
      do_op("srl", 4'd7, 32'h8000_0000, 32'h24);
      do_op("slt", 4'd3, 32'hFFFF_FFFF, 32'd1);
      do_op("undef", 4'd13, 32'd9, 32'd9);

      // Start pulsed while dividing must be dropped.
      @(negedge clk);
      start = 1'b1; alu_control = 4'd4; a = 32'd100; b = 32'd7;
      dones = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 5) begin start = 1'b1; alu_control = 4'd0; a = 32'd1; b = 32'd2; end
         if (done === 1'b1) dones++;
         if (c == 33) begin
            chk("ign done@33", {31'd0, done}, 32'd1);
            chk("ign result@33", result, 32'd14);
         end
      end
      chk("ign done_count", 32'(dones), 32'd1);

      // Reset mid-division aborts with no completion.
      @(negedge clk);
      start = 1'b1; alu_control = 4'd4; a = 32'd100; b = 32'd7;
      dones = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         reset = (c == 10);
         if (c == 11) begin
            chk("abort busy", {31'd0, busy}, 32'd0);
            chk("abort result", result, 32'd0);
            chk("abort zero", {31'd0, zero}, 32'd1);
         end
         if (done === 1'b1) dones++;
      end
      chk("abort no_done", 32'(dones), 32'd0);

      // Reset and start together: start dropped.
      @(negedge clk);
      reset = 1'b1; start = 1'b1; alu_control = 4'd0; a = 32'd3; b = 32'd4;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_start busy", {31'd0, busy}, 32'd0);
      chk("rst_start done", {31'd0, done}, 32'd0);
      chk("rst_start result", result, 32'd0);

      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: y = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
            3: x = 32'd0;
            default: ;
         endcase
         if (i % 4 == 0) op = 4'($urandom_range(4, 5));
         do_op($sformatf("rnd%0d_op%0d", i, op), op, x, y);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
